// File: rtl/host_interface_pkg.sv
// Shared definitions for the host interface: job FSM states and the fixed shared-memory map.
package host_interface_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrConfig,
    StPollWait,
    StPollRead,
    StPollCheck,
    StUnload,
    StFinish
  } state_e;

  localparam int unsigned CONFIG_ADDR     = 0;
  localparam int unsigned STATUS_ADDR     = 1;
  localparam int unsigned OPERAND_BASE    = 2;
  localparam int unsigned STATUS_DONE_BIT = 0;

endpackage

// File: rtl/host_interface_if.sv
// Operand stream, result stream and shared-memory port of the host interface.
interface host_interface_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_W    = 10
);

  logic                 i_Host_Valid;
  logic [WORD_SIZE-1:0] i_Host_Data;
  logic                 o_Host_Ready;

  logic                 o_Out_Valid;
  logic [WORD_SIZE-1:0] o_Out_Data;
  logic                 i_Out_Ready;

  logic                 o_Request;
  logic                 i_Grant;
  logic [ADDR_W-1:0]    o_Mem_Address;
  logic [WORD_SIZE-1:0] o_Mem_Write_Data;
  logic                 o_Mem_Write_Enable;
  logic                 o_Mem_Read_Enable;
  logic [WORD_SIZE-1:0] i_Mem_Read_Data;

  modport master (
    input  i_Host_Valid, i_Host_Data, i_Out_Ready, i_Grant, i_Mem_Read_Data,
    output o_Host_Ready, o_Out_Valid, o_Out_Data, o_Request, o_Mem_Address,
           o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Read_Enable
  );

  modport slave (
    output i_Host_Valid, i_Host_Data, i_Out_Ready, i_Grant, i_Mem_Read_Data,
    input  o_Host_Ready, o_Out_Valid, o_Out_Data, o_Request, o_Mem_Address,
           o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Read_Enable
  );

endinterface

// File: rtl/host_skid_buffer.sv
// One-entry output register for the result stream; holds a word until the consumer takes it.
module host_skid_buffer #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_In_Valid,
  input  logic [WORD_SIZE-1:0] i_In_Data,
  output logic                 o_Has_Room,
  output logic                 o_Out_Valid,
  output logic [WORD_SIZE-1:0] o_Out_Data,
  input  logic                 i_Out_Ready
);

  logic                 r_valid;
  logic [WORD_SIZE-1:0] r_data;

  // The producer only pushes when the entry is empty or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_In_Valid) begin
      r_valid <= 1'b1;
      r_data  <= i_In_Data;
    end else if (i_Out_Ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_Has_Room  = !r_valid || i_Out_Ready;
  assign o_Out_Valid = r_valid;
  assign o_Out_Data  = r_data;

endmodule

// File: rtl/host_interface.sv
// Host-side job sequencer: streams operands into shared memory, writes config, polls status,
// then streams the result region back out.
module host_interface
  import host_interface_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned MEMORY_SIZE   = 1024,
  parameter int unsigned POLL_INTERVAL = 8,
  localparam int unsigned ADDR_W       = $clog2(MEMORY_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_Start,
  input  logic [WORD_SIZE-1:0] i_Config,
  input  logic [ADDR_W-1:0]    i_Load_Words,
  input  logic [ADDR_W-1:0]    i_Result_Base,
  input  logic [ADDR_W-1:0]    i_Result_Words,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_Error,
  host_interface_if.master     bus
);

  localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);

  state_e               r_state, w_state_next;
  logic [WORD_SIZE-1:0] r_config;
  logic [ADDR_W-1:0]    r_load_words, r_result_base, r_result_words;
  logic [ADDR_W-1:0]    r_k, w_k_next, r_j, w_j_next;
  logic [POLL_W-1:0]    r_poll, w_poll_next;
  logic                 r_pending, w_pending_next, r_error;
  logic [ADDR_W:0]      w_load_end, w_result_end;
  logic                 w_too_big, w_accept;
  logic                 w_request, w_host_ready, w_we, w_re, w_done;
  logic [ADDR_W-1:0]    w_addr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic                 w_has_room, w_out_valid;
  logic [WORD_SIZE-1:0] w_out_data;

  // One extra bit so the region-end sums cannot wrap before the bounds check.
  assign w_load_end   = {1'b0, i_Load_Words} + (ADDR_W + 1)'(OPERAND_BASE);
  assign w_result_end = {1'b0, i_Result_Base} + {1'b0, i_Result_Words};
  assign w_too_big    = (w_load_end > (ADDR_W + 1)'(MEMORY_SIZE)) ||
                        (w_result_end > (ADDR_W + 1)'(MEMORY_SIZE));
  assign w_accept     = (r_state == StIdle) && i_Start && !w_too_big;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_config       <= '0;
      r_load_words   <= '0;
      r_result_base  <= '0;
      r_result_words <= '0;
      r_k            <= '0;
      r_j            <= '0;
      r_poll         <= '0;
      r_pending      <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_k       <= w_k_next;
      r_j       <= w_j_next;
      r_poll    <= w_poll_next;
      r_pending <= w_pending_next;
      r_error   <= (r_state == StIdle) && i_Start && w_too_big;
      if (w_accept) begin
        r_config       <= i_Config;
        r_load_words   <= i_Load_Words;
        r_result_base  <= i_Result_Base;
        r_result_words <= i_Result_Words;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_k_next       = r_k;
    w_j_next       = r_j;
    w_poll_next    = r_poll;
    w_pending_next = 1'b0;
    w_request      = 1'b0;
    w_host_ready   = 1'b0;
    w_we           = 1'b0;
    w_re           = 1'b0;
    w_addr         = '0;
    w_wdata        = '0;
    w_done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_k_next    = '0;
        w_j_next    = '0;
        w_poll_next = '0;
        if (w_accept) w_state_next = StLoad;
      end
      StLoad: begin
        w_request = 1'b1;
        if (r_load_words == '0) begin
          w_state_next = StWrConfig;
        end else begin
          w_host_ready = bus.i_Grant;
          if (bus.i_Grant && bus.i_Host_Valid) begin
            w_we    = 1'b1;
            w_addr  = ADDR_W'(OPERAND_BASE) + r_k;
            w_wdata = bus.i_Host_Data;
            if (r_k == r_load_words - ADDR_W'(1)) begin
              w_k_next     = '0;
              w_state_next = StWrConfig;
            end else begin
              w_k_next = r_k + ADDR_W'(1);
            end
          end
        end
      end
      StWrConfig: begin
        w_request = 1'b1;
        if (bus.i_Grant) begin
          w_we         = 1'b1;
          w_addr       = ADDR_W'(CONFIG_ADDR);
          w_wdata      = r_config;
          w_poll_next  = '0;
          w_state_next = StPollWait;
        end
      end
      StPollWait: begin
        if (r_poll == POLL_LAST) begin
          w_poll_next  = '0;
          w_state_next = StPollRead;
        end else begin
          w_poll_next = r_poll + POLL_W'(1);
        end
      end
      StPollRead: begin
        w_request = 1'b1;
        if (bus.i_Grant) begin
          w_re         = 1'b1;
          w_addr       = ADDR_W'(STATUS_ADDR);
          w_state_next = StPollCheck;
        end
      end
      StPollCheck: begin
        // Read data for the status access issued in the previous cycle.
        if (bus.i_Mem_Read_Data[STATUS_DONE_BIT]) begin
          w_j_next     = '0;
          w_state_next = (r_result_words == '0) ? StFinish : StUnload;
        end else begin
          w_state_next = StPollWait;
        end
      end
      StUnload: begin
        w_request = (r_j != r_result_words);
        // One read in flight at most, and only if its word is sure to find the buffer free.
        if (bus.i_Grant && (r_j != r_result_words) && !r_pending && w_has_room) begin
          w_re           = 1'b1;
          w_addr         = r_result_base + r_j;
          w_j_next       = r_j + ADDR_W'(1);
          w_pending_next = 1'b1;
        end
        if ((r_j == r_result_words) && !r_pending && w_out_valid && bus.i_Out_Ready) begin
          w_state_next = StFinish;
        end
      end
      StFinish: begin
        w_done       = 1'b1;
        w_j_next     = '0;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  host_skid_buffer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_In_Valid  (r_pending),
    .i_In_Data   (bus.i_Mem_Read_Data),
    .o_Has_Room  (w_has_room),
    .o_Out_Valid (w_out_valid),
    .o_Out_Data  (w_out_data),
    .i_Out_Ready (bus.i_Out_Ready)
  );

  assign bus.o_Host_Ready       = w_host_ready;
  assign bus.o_Out_Valid        = w_out_valid;
  assign bus.o_Out_Data         = w_out_data;
  assign bus.o_Request          = w_request;
  assign bus.o_Mem_Address      = w_addr;
  assign bus.o_Mem_Write_Data   = w_wdata;
  assign bus.o_Mem_Write_Enable = w_we;
  assign bus.o_Mem_Read_Enable  = w_re;

  assign o_Busy  = (r_state != StIdle);
  assign o_Done  = w_done;
  assign o_Error = r_error;

endmodule

// File: doc/host_interface.md
HOST_INTERFACE -- requirements
Module: host_interface

Interface
REQ-001 Parameter WORD_SIZE, default 32: memory data width.
REQ-002 Parameter MEMORY_SIZE, default 1024: words in shared memory; ADDR_W = clog2(MEMORY_SIZE).
REQ-003 Parameter POLL_INTERVAL, default 8: idle cycles between status reads.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 i_Start  input  1  one-cycle pulse that begins a job; ignored unless IDLE.
REQ-007 i_Config  input  WORD_SIZE  config word, captured on i_Start.
REQ-008 i_Load_Words  input  ADDR_W  operand word count, captured on i_Start.
REQ-009 i_Result_Base / i_Result_Words  input  ADDR_W each  result region, captured on i_Start.
REQ-010 i_Host_Valid / i_Host_Data / o_Host_Ready  in 1 / in WORD_SIZE / out 1  operand stream; transfer when Valid and Ready are both high.
REQ-011 o_Out_Valid / o_Out_Data / i_Out_Ready  out 1 / out WORD_SIZE / in 1  result stream, same handshake.
REQ-012 o_Request / i_Grant  out 1 / in 1  shared-memory arbitration; memory outputs are driven only while i_Grant is high.
REQ-013 o_Mem_Address, o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Read_Enable  out ADDR_W / WORD_SIZE / 1 / 1  memory port.
REQ-014 i_Mem_Read_Data  input  WORD_SIZE  read data, valid exactly one cycle after a granted read.
REQ-015 o_Busy / o_Done / o_Error  out 1 each  job active / one-cycle completion pulse / one-cycle rejection pulse.

Function
REQ-016 States: IDLE, LOAD, WR_CONFIG, POLL_WAIT, POLL_READ, POLL_CHECK, UNLOAD, FINISH.
REQ-017 IDLE + i_Start: if 2+i_Load_Words > MEMORY_SIZE, or i_Result_Base+i_Result_Words > MEMORY_SIZE, pulse o_Error next cycle and stay IDLE; otherwise latch inputs and go to LOAD.
REQ-018 Fixed map: address 0 = config, address 1 = status (bit 0 = done); operand k goes to address 2+k.
REQ-019 LOAD: o_Request high. o_Host_Ready = i_Grant; each transfer writes address 2+k in the same cycle (o_Mem_Write_Enable=1). After i_Load_Words transfers go to WR_CONFIG; i_Load_Words=0 goes straight to WR_CONFIG.
REQ-020 WR_CONFIG: on the first granted cycle, write the latched config to address 0, then go to POLL_WAIT.
REQ-021 POLL_WAIT: o_Request low; count POLL_INTERVAL cycles, then go to POLL_READ.
REQ-022 POLL_READ: o_Request high; on the first granted cycle, read address 1, then go to POLL_CHECK.
REQ-023 POLL_CHECK: sample i_Mem_Read_Data[0]. If 1, go to UNLOAD (or FINISH if i_Result_Words=0). If 0, go back to POLL_WAIT.
REQ-024 UNLOAD: one-entry skid buffer. Issue a read at i_Result_Base+j only when the buffer is, or will be, empty and i_Grant is high. Data appears on o_Out_Data/o_Out_Valid the next cycle and is held until i_Out_Ready. Word order is ascending address; no word is dropped or duplicated under backpressure or grant loss.
REQ-025 After the last word is accepted go to FINISH; FINISH pulses o_Done for one cycle and returns to IDLE.
REQ-026 o_Busy is high in every state except IDLE.
REQ-027 With i_Grant low, memory enables are 0 and no counter advances.
REQ-028 i_Start during a job is ignored.
REQ-029 Address arithmetic is ADDR_W wide; overflow is excluded by the REQ-017 check.

Reset
REQ-030 Reset forces IDLE immediately, including mid-job; no further memory access occurs.
REQ-031 Reset values: all outputs 0, all counters 0, skid buffer empty. Memory contents are not restored.

Structure
REQ-032 A shared package holds the state enumeration, CONFIG_ADDR=0, STATUS_ADDR=1, OPERAND_BASE=2, and STATUS_DONE_BIT=0.
REQ-033 One sub-module, host_skid_buffer (one-entry valid/ready register), implements the UNLOAD output stage.

Verification
REQ-034 Load 3 words {A,B,C}, config 0x0000_0103, grant always high -> writes to addresses 2,3,4 then 0x0000_0103 to address 0; first status read 8 cycles later.
REQ-035 Status reads 0 twice, then 1 -> exactly three reads of address 1 spaced by POLL_INTERVAL; UNLOAD starts after the third.
REQ-036 Result base 0x100, 4 words, i_Out_Ready toggled every other cycle -> o_Out_Data presents mem[0x100..0x103] in order, each exactly once; o_Done pulses once.
REQ-037 i_Load_Words=1023 with MEMORY_SIZE=1024 -> o_Error pulses one cycle; no memory enable asserted; o_Busy stays 0.
REQ-038 Grant dropped for 5 cycles mid-LOAD with Host_Valid high -> o_Host_Ready is 0 during the gap and no writes occur; the load resumes at the next address.
REQ-039 Reset asserted during UNLOAD (any clock phase) -> all outputs 0 immediately; a new i_Start runs a full job correctly.
